// File: rtl/sprite_line_reader_if.sv
// Descriptor RAM read port between the sprite line reader and the sprite
// descriptor RAM. Read data is returned one cycle after rd_en.
interface sprite_line_reader_if;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/sprite_line_reader.sv
// Sprite line reader: scans the 8 descriptor slots during hblank, keeps up to
// MAX_PER_LINE sprites crossing the next line, and resolves per pixel which
// sprite (lowest slot) covers it, producing the sprite-sheet ROM address.
module sprite_line_reader #(
  parameter int SPRITE_LOG2  = 5,
  parameter int MAX_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [9:0]            next_y,
  input  logic                  pixel_valid,
  input  logic [9:0]            pixel_x,
  sprite_line_reader_if.master  ram,
  output logic                  scan_busy,
  output logic                  sprite_hit,
  output logic [2:0]            sprite_slot,
  output logic [15:0]           sprite_rom_addr,
  output logic                  line_overflow
);

  localparam int          CW   = $clog2(MAX_PER_LINE + 1);
  localparam logic [10:0] EDGE = 11'(1 << SPRITE_LOG2);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  y_q, y_d;
  logic        start, commit;

  // Staging buffer (filled during the scan) and active buffer (used for pixels)
  logic [9:0]  stg_x_q[MAX_PER_LINE], res_x[MAX_PER_LINE], act_x_q[MAX_PER_LINE];
  logic [4:0]  stg_dy_q[MAX_PER_LINE], res_dy[MAX_PER_LINE], act_dy_q[MAX_PER_LINE];
  logic [2:0]  stg_row_q[MAX_PER_LINE], res_row[MAX_PER_LINE], act_row_q[MAX_PER_LINE];
  logic [2:0]  stg_col_q[MAX_PER_LINE], res_col[MAX_PER_LINE], act_col_q[MAX_PER_LINE];
  logic [2:0]  stg_slot_q[MAX_PER_LINE], res_slot[MAX_PER_LINE], act_slot_q[MAX_PER_LINE];
  logic [CW-1:0] stg_cnt_q, res_cnt, act_cnt_q;
  logic        stg_ovf_q, res_ovf, ovf_q;

  logic        hit_q;
  logic [2:0]  slot_q;
  logic [15:0] addr_q;

  // Descriptor fields of the word returned for slot cnt_q-1
  logic        eval, cand;
  logic [9:0]  w_x, w_y;
  logic [10:0] w_dy;
  logic        unused_rsvd;

  assign eval        = (state_q == FETCH) && (cnt_q != 4'd0);
  assign w_x         = ram.rd_data[25:16];
  assign w_y         = ram.rd_data[15:6];
  assign w_dy        = {1'b0, y_q} - {1'b0, w_y};
  assign cand        = eval && ram.rd_data[31] && (y_q >= w_y) && (w_dy < EDGE);
  assign unused_rsvd = ^ram.rd_data[30:26];

  assign ram.rd_en   = (state_q == FETCH) && !cnt_q[3];
  assign ram.rd_addr = ram.rd_en ? cnt_q[2:0] : 3'd0;
  assign scan_busy   = (state_q == FETCH);

  // Scan FSM: slot counter, latched line, start/commit decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) start = 1'b1;
      end
      FETCH: begin
        if (cnt_q == 4'd8) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        if (line_start) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = FETCH;
      cnt_d   = 4'd0;
      y_d     = next_y;
    end
  end

  // Staging insertion: append a candidate or flag overflow when full
  always_comb begin
    res_x    = stg_x_q;
    res_dy   = stg_dy_q;
    res_row  = stg_row_q;
    res_col  = stg_col_q;
    res_slot = stg_slot_q;
    res_cnt  = stg_cnt_q;
    res_ovf  = stg_ovf_q;
    if (cand) begin
      if (stg_cnt_q < CW'(MAX_PER_LINE)) begin
        for (int i = 0; i < MAX_PER_LINE; i++) begin
          if (stg_cnt_q == CW'(i)) begin
            res_x[i]    = w_x;
            res_dy[i]   = w_dy[4:0];
            res_row[i]  = ram.rd_data[5:3];
            res_col[i]  = ram.rd_data[2:0];
            res_slot[i] = cnt_q[2:0] - 3'd1;
          end
        end
        res_cnt = stg_cnt_q + CW'(1);
      end else begin
        res_ovf = 1'b1;
      end
    end
  end

  // Per-entry pixel match against the active buffer
  logic        hit_w[MAX_PER_LINE];
  logic [10:0] dx_w[MAX_PER_LINE];
  for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_match
    assign dx_w[g]  = {1'b0, pixel_x} - {1'b0, act_x_q[g]};
    assign hit_w[g] = pixel_valid && (CW'(g) < act_cnt_q) &&
                      (pixel_x >= act_x_q[g]) && (dx_w[g] < EDGE);
  end

  // Priority pick: lowest entry index (lowest slot) wins
  logic        win;
  logic [2:0]  win_slot;
  logic [15:0] win_addr;
  always_comb begin
    win      = 1'b0;
    win_slot = 3'd0;
    win_addr = 16'd0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (hit_w[i]) begin
        win      = 1'b1;
        win_slot = act_slot_q[i];
        win_addr = {act_row_q[i], act_col_q[i], act_dy_q[i], dx_w[i][4:0]};
      end
    end
  end

  // Control state, counts and registered pixel result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      stg_cnt_q <= '0;
      stg_ovf_q <= 1'b0;
      act_cnt_q <= '0;
      ovf_q     <= 1'b0;
      hit_q     <= 1'b0;
      slot_q    <= 3'd0;
      addr_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stg_cnt_q <= start ? '0 : res_cnt;
      stg_ovf_q <= start ? 1'b0 : res_ovf;
      if (commit) begin
        act_cnt_q <= res_cnt;
        ovf_q     <= res_ovf;
      end
      hit_q  <= win;
      slot_q <= win_slot;
      addr_q <= win_addr;
    end
  end

  // Buffer contents; only the counts above decide which entries are live
  always_ff @(posedge clk) begin
    y_q        <= y_d;
    stg_x_q    <= res_x;
    stg_dy_q   <= res_dy;
    stg_row_q  <= res_row;
    stg_col_q  <= res_col;
    stg_slot_q <= res_slot;
    if (commit) begin
      act_x_q    <= res_x;
      act_dy_q   <= res_dy;
      act_row_q  <= res_row;
      act_col_q  <= res_col;
      act_slot_q <= res_slot;
    end
  end

  assign sprite_hit      = hit_q && !scan_busy;
  assign sprite_slot     = sprite_hit ? slot_q : 3'd0;
  assign sprite_rom_addr = sprite_hit ? addr_q : 16'd0;
  assign line_overflow   = ovf_q;

endmodule

// File: tb/tb_sprite_line_reader.sv
// Self-checking bench for sprite_line_reader: descriptor RAM model, scan timing
// checks and a pixel scoreboard fed by a reference line model.
module tb_sprite_line_reader;

  localparam int MAXP = 4;
  localparam int SEDGE = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  next_y;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic        scan_busy, sprite_hit, line_overflow;
  logic [2:0]  sprite_slot;
  logic [15:0] sprite_rom_addr;

  sprite_line_reader_if bus ();

  sprite_line_reader #(.SPRITE_LOG2(5), .MAX_PER_LINE(MAXP)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .next_y(next_y),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .ram(bus),
    .scan_busy(scan_busy), .sprite_hit(sprite_hit), .sprite_slot(sprite_slot),
    .sprite_rom_addr(sprite_rom_addr), .line_overflow(line_overflow));

  always #5 clk = ~clk;

  logic [31:0] mem[8];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [9:0] x;
    logic [4:0] dy;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] slot;
  } ent_t;

  ent_t m_ent[$];
  bit   m_ovf = 1'b0;
  logic [19:0] sb[$];

  function automatic logic [31:0] desc(bit en, int x, int y, int row, int col);
    return {en, 5'b0, 10'(x), 10'(y), 3'(row), 3'(col)};
  endfunction

  task automatic model_scan(input int y);
    logic [31:0] w;
    int px, py;
    ent_t e;
    m_ent.delete();
    m_ovf = 1'b0;
    for (int s = 0; s < 8; s++) begin
      w  = mem[s];
      px = int'(w[25:16]);
      py = int'(w[15:6]);
      if (w[31] && y >= py && (y - py) < SEDGE) begin
        if (m_ent.size() < MAXP) begin
          e.x = 10'(px); e.dy = 5'(y - py); e.row = w[5:3]; e.col = w[2:0]; e.slot = 3'(s);
          m_ent.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_pix(input int x);
    foreach (m_ent[i]) begin
      if (x >= int'(m_ent[i].x) && (x - int'(m_ent[i].x)) < SEDGE)
        return {1'b1, m_ent[i].slot, m_ent[i].row, m_ent[i].col, m_ent[i].dy,
                5'(x - int'(m_ent[i].x))};
    end
    return 20'd0;
  endfunction

  function automatic logic [31:0] obs();
    return {12'd0, sprite_hit, sprite_slot, sprite_rom_addr};
  endfunction

  // Sweep active pixels lo..hi; expected results queued at drive, compared one cycle later
  task automatic sweep(input int lo, input int hi);
    logic [19:0] e;
    for (int x = lo; x <= hi + 1; x++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("pix", obs(), {12'd0, e});
      end
      if (x <= hi) begin
        pixel_valid = 1'b1;
        pixel_x     = 10'(x);
        sb.push_back(exp_pix(x));
      end else begin
        pixel_valid = 1'b0;
      end
    end
  endtask

  task automatic pix1(input string tag, input int x, input logic [19:0] e);
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel_x     = 10'(x);
    @(negedge clk);
    pixel_valid = 1'b0;
    check_eq(tag, obs(), {12'd0, e});
  endtask

  // Full scan with cycle-exact checks of the read sequence and busy window
  task automatic do_line(input int y);
    @(negedge clk);
    line_start = 1'b1;
    next_y     = 10'(y);
    @(negedge clk);
    line_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("rd_en", {31'd0, bus.rd_en}, 32'd1);
      check_eq("rd_addr", {29'd0, bus.rd_addr}, 32'(k));
      check_eq("busy", {31'd0, scan_busy}, 32'd1);
    end
    @(negedge clk);
    check_eq("rd_en_off", {31'd0, bus.rd_en}, 32'd0);
    check_eq("busy_t9", {31'd0, scan_busy}, 32'd1);
    @(negedge clk);
    model_scan(y);
    check_eq("busy_t10", {31'd0, scan_busy}, 32'd0);
    check_eq("ovf", {31'd0, line_overflow}, {31'd0, m_ovf});
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; next_y = '0; pixel_valid = 1'b0; pixel_x = '0;
    for (int s = 0; s < 8; s++) mem[s] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check_eq("rst_rd_addr", {29'd0, bus.rd_addr}, 32'd0);
    check_eq("rst_busy", {31'd0, scan_busy}, 32'd0);
    check_eq("rst_pix", obs(), 32'd0);
    check_eq("rst_ovf", {31'd0, line_overflow}, 32'd0);
    sweep(0, 639);

    // Single sprite, x/y window edges
    mem[0] = desc(1, 80, 400, 0, 2);
    do_line(410);
    pix1("x79", 79, 20'd0);
    pix1("x80", 80, {1'b1, 3'd0, 16'h0940});
    pix1("x111", 111, {1'b1, 3'd0, 16'h095F});
    pix1("x112", 112, 20'd0);
    sweep(60, 130);
    do_line(431);
    pix1("dy31", 80, {1'b1, 3'd0, 16'h0BE0});
    sweep(70, 120);
    do_line(432);
    pix1("y432", 80, 20'd0);
    do_line(399);
    pix1("y399", 80, 20'd0);
    mem[0] = desc(1, 80, 1000, 0, 2);
    do_line(5);
    pix1("nowrap", 80, 20'd0);
    sweep(70, 120);

    // Slot priority
    mem[0] = 32'd0;
    mem[2] = desc(1, 200, 100, 3, 1);
    mem[5] = desc(1, 200, 100, 5, 6);
    do_line(110);
    pix1("slot2", 200, {1'b1, 3'd2, 16'h6540});
    sweep(190, 240);
    mem[2][31] = 1'b0;
    do_line(110);
    pix1("slot5", 200, {1'b1, 3'd5, 16'hB940});
    mem[5] = 32'd0;
    do_line(110);
    pix1("none", 200, 20'd0);

    // Overflow: six candidates, four kept
    for (int s = 0; s < 6; s++) mem[s] = desc(1, s * 64, 50, s, s);
    do_line(60);
    check_eq("ovf6", {31'd0, line_overflow}, 32'd1);
    pix1("slot4none", 256, 20'd0);
    sweep(0, 400);
    mem[4][31] = 1'b0;
    mem[5][31] = 1'b0;
    do_line(60);
    check_eq("ovf4", {31'd0, line_overflow}, 32'd0);

    // Restart by line_start at T+4: old overflow persists until the new commit
    mem[4][31] = 1'b1;
    mem[5][31] = 1'b1;
    do_line(60);
    for (int s = 1; s < 6; s++) mem[s] = 32'd0;
    @(negedge clk); line_start = 1'b1; next_y = 10'd60;
    @(negedge clk); line_start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); line_start = 1'b1; next_y = 10'd70;
    @(negedge clk); line_start = 1'b0;
    check_eq("rs_addr0", {29'd0, bus.rd_addr}, 32'd0);
    check_eq("rs_rd_en", {31'd0, bus.rd_en}, 32'd1);
    for (int c = 5; c <= 13; c++) begin
      if (c > 5) @(negedge clk);
      check_eq("rs_busy", {31'd0, scan_busy}, 32'd1);
      check_eq("rs_ovf_keep", {31'd0, line_overflow}, 32'd1);
    end
    @(negedge clk);
    model_scan(70);
    check_eq("rs_done", {31'd0, scan_busy}, 32'd0);
    check_eq("rs_ovf", {31'd0, line_overflow}, 32'd0);
    pix1("rs_newy", 10, {1'b1, 3'd0, 16'h028A});
    sweep(0, 100);

    // line_start on the commit cycle: commit and immediate new scan
    for (int s = 0; s < 6; s++) mem[s] = desc(1, s * 64, 50, s, s);
    @(negedge clk); line_start = 1'b1; next_y = 10'd60;
    @(negedge clk); line_start = 1'b0;
    repeat (8) @(negedge clk);
    line_start = 1'b1;
    check_eq("cm_busy9", {31'd0, scan_busy}, 32'd1);
    @(negedge clk); line_start = 1'b0;
    check_eq("cm_busy10", {31'd0, scan_busy}, 32'd1);
    check_eq("cm_addr0", {29'd0, bus.rd_addr}, 32'd0);
    check_eq("cm_ovf", {31'd0, line_overflow}, 32'd1);
    repeat (8) @(negedge clk);
    check_eq("cm_busy18", {31'd0, scan_busy}, 32'd1);
    @(negedge clk);
    check_eq("cm_busy19", {31'd0, scan_busy}, 32'd0);
    model_scan(60);
    sweep(0, 400);

    // Reset at T+4 abandons the scan
    @(negedge clk); line_start = 1'b1; next_y = 10'd60;
    @(negedge clk); line_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rm_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check_eq("rm_busy", {31'd0, scan_busy}, 32'd0);
    check_eq("rm_ovf", {31'd0, line_overflow}, 32'd0);
    reset = 1'b0;
    m_ent.delete();
    m_ovf = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rm_busy_late", {31'd0, scan_busy}, 32'd0);
    check_eq("rm_ovf_late", {31'd0, line_overflow}, 32'd0);
    sweep(0, 400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_line_reader.md
# sprite_line_reader

Read side of the 8-slot sprite descriptor RAM that game-object blocks (player, obstacles) write. Once per scanline, during horizontal blanking, the block scans all slots. It keeps up to MAX_PER_LINE sprites that intersect the upcoming line. During the active line it resolves, per pixel, which sprite covers the pixel and emits the sprite-sheet ROM address for the pixel stage that follows.

## Interface
Parameters:
- SPRITE_LOG2, default 5: sprite edge is 2^SPRITE_LOG2 pixels (32×32).
- MAX_PER_LINE, default 4: maximum sprites kept per line (1–8).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- line_start  in  1  one-cycle pulse at the start of hblank preceding line next_y
- next_y  in  10  y coordinate of the line about to be displayed; sampled on line_start
- pixel_valid  in  1  pixel_x is an active pixel this cycle
- pixel_x  in  10  current pixel x coordinate
- rd_en  out  1  descriptor RAM read enable
- rd_addr  out  3  descriptor slot address
- rd_data  in  32  descriptor word, valid one cycle after rd_en
- scan_busy  out  1  a slot scan is in progress
- sprite_hit  out  1  a sprite covers the previous cycle's pixel
- sprite_slot  out  3  slot number of the winning sprite
- sprite_rom_addr  out  16  {rom_row[2:0], rom_col[2:0], dy[4:0], dx[4:0]}
- line_overflow  out  1  more than MAX_PER_LINE candidates on the current line

## Operation
- Descriptor word layout:
  - [31] enable
  - [30:26] reserved; ignored on read
  - [25:16] pos_x
  - [15:6] pos_y
  - [5:3] rom_row
  - [2:0] rom_col
- FSM states are IDLE and FETCH.
- IDLE → FETCH on line_start:
  - latch next_y
  - clear the staging buffer and the staging overflow flag
  - zero the slot counter
- FETCH issues rd_en=1 with rd_addr = 0..7 on consecutive cycles, then deasserts rd_en.
- Each returned word is evaluated. It is a candidate iff enable=1, next_y ≥ pos_y, and (next_y − pos_y) < 2^SPRITE_LOG2.
  - Compare in 11-bit unsigned arithmetic; a wrapped difference never qualifies.
- Candidates fill the staging entries in ascending slot order. Each entry stores pos_x, dy = (next_y − pos_y)[4:0], rom_row, rom_col and slot.
- A candidate arriving when staging already holds MAX_PER_LINE entries is dropped and sets staging overflow.
- After slot 7 is evaluated, commit staging to the active buffer, copy staging overflow to line_overflow, and return to IDLE.
- line_start while in FETCH aborts the scan and restarts it from slot 0 with the new next_y. The active buffer and line_overflow are left unchanged.
- Pixel match, per active entry i: hit_i = pixel_valid & (pixel_x ≥ x_i) & ((pixel_x − x_i) < 2^SPRITE_LOG2), using 11-bit unsigned compare.
  - Lowest entry index wins, which is the lowest slot number.
  - dx = (pixel_x − x_i)[4:0].
- No winner: sprite_hit=0, sprite_slot=0, sprite_rom_addr=0.
- While scan_busy=1, sprite_hit is forced to 0.
- Transparency is not handled here; it is resolved downstream from ROM data.

## Timing
- Let line_start be asserted at cycle T.
  - rd_addr=k with rd_en=1 at cycle T+1+k, for k=0..7.
  - rd_data for slot k is sampled at T+2+k.
  - scan_busy=1 during cycles T+1..T+9.
  - The active buffer and line_overflow are updated at the T+10 edge; scan_busy=0 from T+10.
- Pixel path has 1-cycle registered latency. pixel_x at cycle t produces sprite_hit, sprite_slot and sprite_rom_addr at t+1.
- Reset values:
  - rd_en=0, rd_addr=0, scan_busy=0
  - sprite_hit=0, sprite_slot=0, sprite_rom_addr=0, line_overflow=0
  - active and staging counts = 0; FSM in IDLE
- Reset mid-scan takes effect on the next edge and abandons the scan; no commit occurs.
- line_start simultaneous with the commit cycle: the commit happens and the new scan starts at T+1 as normal.

## Test plan
- Reset → all outputs 0. With no line_start, pixel_valid sweeping x=0..639 gives sprite_hit=0 throughout.
- Slot 0 = {en=1, x=80, y=400, row=0, col=2}; line_start with next_y=410; wait until scan_busy=0; then sweep pixels:
  - x=79 → hit=0
  - x=80 → hit=1, rom_addr={0,2,10,0}, slot=0
  - x=111 → dx=31
  - x=112 → hit=0
- Same slot 0 descriptor:
  - next_y=431 → hit with dy=31
  - next_y=432 → no hit
  - next_y=399 → no hit
  - pos_y=1000 with next_y=5 → no hit (no wrap)
- Slots 2 and 5 enabled at identical x/y → slot=2 reported. Slot 2's enable cleared → slot=5 reported. All enables 0 → no hits.
- Six enabled sprites on one line (slots 0–5, disjoint x), MAX_PER_LINE=4 → slots 0–3 hit, slots 4–5 never hit, line_overflow=1. On the next line with ≤4 candidates, line_overflow=0.
- Mid-scan events:
  - line_start during a scan at T+4 → rd_addr restarts at 0, scan_busy extends to T+4+9, and the previous line's hits persist until commit.
  - reset at T+4 → rd_en=0 next cycle and no commit occurs.
